// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// 16-entry integer register file with a busy-bit scoreboard for the in-order
// pipeline. The write port takes the one-hot write-enable bus produced by the
// upstream 4-to-16 address decoder, together with the writeback data. Two
// registered read ports serve operand fetch. The scoreboard tracks pending
// destinations so that issue stalls on RAW and WAW hazards.
//
// Parameters
//   DATA_WIDTH  width of each register and of every data port
//   ZERO_REG    1: register 15 reads as zero, ignores writes, is never busy
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   wr_onehot  one-hot write enable (all-zero = no write)
//   wr_data    writeback data
//   rd_en      launch a read of both ports this cycle
//   rd_addr_a  read port A index
//   rd_addr_b  read port B index
//   rd_data_a  port A data, registered (holds when rd_en=0)
//   rd_data_b  port B data, registered (holds when rd_en=0)
//   rd_valid   rd_en delayed by one cycle
//   iss_valid  an instruction requests issue this cycle
//   iss_dest   destination register of the issuing instruction
//   iss_src_a  source A of the issuing instruction
//   iss_src_b  source B of the issuing instruction
//   iss_stall  combinational issue block (RAW/WAW hazard)
//   busy       scoreboard bits, registered
//   wr_err     sticky: a multi-bit wr_onehot was seen
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           wr_onehot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [3:0]            rd_addr_a,
    input  logic [3:0]            rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid,
    input  logic                  iss_valid,
    input  logic [3:0]            iss_dest,
    input  logic [3:0]            iss_src_a,
    input  logic [3:0]            iss_src_b,
    output logic                  iss_stall,
    output logic [15:0]           busy,
    output logic                  wr_err
);

    // Bits that may ever be written or marked busy; register 15 is excluded
    // when it is the hardwired zero register.
    localparam logic [15:0] REG_MASK = ZERO_REG ? 16'h7FFF : 16'hFFFF;

    logic [DATA_WIDTH-1:0] regs_q [16];
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_q;
    logic [15:0]           busy_q, busy_d;
    logic                  wr_err_q, wr_err_d;

    logic                  wr_multi;
    logic                  wr_single;
    logic [15:0]           wr_we;
    logic [15:0]           busy_eff;
    logic [15:0]           busy_set;
    logic                  stall;
    logic                  iss_accept;

    // Read value for one port: the zero register wins, then a same-edge
    // write (bypass), then the stored value.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [3:0]            addr,
        input logic                  wr_hit,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (ZERO_REG && addr == 4'd15) begin
            return '0;
        end else if (wr_hit) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    // Write decode. x & (x-1) is non-zero exactly when two or more bits are
    // set; such a write is rejected completely (no data, no busy clear).
    always_comb begin
        wr_multi  = (wr_onehot & (wr_onehot - 16'd1)) != 16'd0;
        wr_single = (wr_onehot != 16'd0) && !wr_multi;
        wr_we     = wr_single ? (wr_onehot & REG_MASK) : 16'd0;
        wr_err_d  = wr_err_q | wr_multi;
    end

    // Scoreboard. Writeback releases its hazard in the same cycle, so the
    // stall check looks at busy after this cycle's clear. The set is OR-ed in
    // after the clear so an issue to the register being written back wins.
    always_comb begin
        busy_eff   = busy_q & ~wr_we;
        stall      = iss_valid & (busy_eff[iss_src_a] | busy_eff[iss_src_b] |
                                  busy_eff[iss_dest]);
        iss_accept = iss_valid & ~stall;
        busy_set   = iss_accept ? ((16'd1 << iss_dest) & REG_MASK) : 16'd0;
        busy_d     = (busy_eff | busy_set) & REG_MASK;
    end

    // Read ports hold their last value when no read is launched.
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en) begin
            rd_data_a_d = read_port(rd_addr_a, wr_we[rd_addr_a], wr_data,
                                    regs_q[rd_addr_a]);
            rd_data_b_d = read_port(rd_addr_b, wr_we[rd_addr_b], wr_data,
                                    regs_q[rd_addr_b]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_we[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 16'd0;
            wr_err_q    <= 1'b0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_en;
            busy_q      <= busy_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
    assign iss_stall = stall;
    assign busy      = busy_q;
    assign wr_err    = wr_err_q;

endmodule
